sseg_scan_ctrl: RTL and testbench

Scan scheduler for the 4-digit 7-segment display on Basys3. Time-multiplexes the anodes at a fixed refresh rate and drives an_sel/char_sel into the display output stage. Accepts steering-mode updates (Drive/Neutral/Reverse) over a valid/ready handshake and commits them only at frame boundaries. Blinks the newly active mode character for a programmable number of frames after each change.

---
 rtl/sseg_pkg.sv | 54 +++++
 rtl/sseg_prescaler.sv | 34 +++
 rtl/sseg_scan_ctrl.sv | 108 ++++++++++
 tb/tb_sseg_scan_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/sseg_pkg.sv
`default_nettype none
// ============================================================================
// Module  : sseg_pkg
// Brief   : Shared mode encoding, segment and anode constants for the display.
// Revision: 1.0
// ============================================================================
package sseg_pkg;

    typedef enum logic [1:0] {
        NONE    = 2'b00,
        DRIVE   = 2'b01,
        NEUTRAL = 2'b10,
        REVERSE = 2'b11
    } mode_t;

    // Active-low gfedcba patterns
    localparam logic [6:0] SEG_D     = 7'b0100001;
    localparam logic [6:0] SEG_N     = 7'b0101011;
    localparam logic [6:0] SEG_R     = 7'b0101111;
    localparam logic [6:0] SEG_T     = 7'b0000111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [3:0] AN_SLOT0 = 4'b1110;
    localparam logic [3:0] AN_SLOT1 = 4'b1101;
    localparam logic [3:0] AN_SLOT2 = 4'b1011;
    localparam logic [3:0] AN_SLOT3 = 4'b0111;
    localparam logic [3:0] AN_OFF   = 4'b1111;

    function automatic logic [3:0] slot_anode(input logic [1:0] slot);
        logic [3:0] an;
        case (slot)
            2'd0:    an = AN_SLOT0;
            2'd1:    an = AN_SLOT1;
            2'd2:    an = AN_SLOT2;
            default: an = AN_SLOT3;
        endcase
        return an;
    endfunction

    // Slot 3 is always blank here: the output stage owns that digit.
    function automatic logic [6:0] slot_char(input logic [1:0] slot, input mode_t active);
        logic [6:0] seg;
        seg = SEG_BLANK;
        case (slot)
            2'd0:    if (active == REVERSE) seg = SEG_R;
            2'd1:    if (active == NEUTRAL) seg = SEG_N;
            2'd2:    if (active == DRIVE)   seg = SEG_D;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage : sseg_pkg
`default_nettype wire

// File: rtl/sseg_prescaler.sv
`default_nettype none
// ============================================================================
// Module  : sseg_prescaler
// Brief   : Wrap counter 0..DIV-1, tick_o high on the wrap cycle.
// Revision: 1.0
// ============================================================================
module sseg_prescaler #(
    parameter int DIV = 100000
) (
    input  logic clk,
    input  logic rst,
    output logic tick_o
);

    localparam int            W    = (DIV < 2) ? 1 : $clog2(DIV);
    localparam logic [W-1:0]  LAST = W'(DIV - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign tick_o = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + W'(1);
        if (tick_o) cnt_d = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule : sseg_prescaler
`default_nettype wire

// File: rtl/sseg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : sseg_scan_ctrl
// Brief   : 4-digit anode scan with frame-aligned mode commit and change blink.
// Revision: 1.0
// ============================================================================
module sseg_scan_ctrl
    import sseg_pkg::*;
#(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] mode_in,
    input  logic       mode_valid,
    output logic       mode_ready,
    output logic [3:0] an_sel,
    output logic [6:0] char_sel,
    output logic       frame_start
);

    localparam int             BW         = (BLINK_FRAMES < 1) ? 1 : $clog2(BLINK_FRAMES + 1);
    localparam logic [BW-1:0]  BLINK_LOAD = BW'(BLINK_FRAMES);

    logic          tick;
    logic          frame_wrap;
    logic          xfer;

    logic [1:0]    slot_q,   slot_d;
    mode_t         active_q, active_d;
    mode_t         pmode_q,  pmode_d;
    logic          pend_q,   pend_d;
    logic [BW-1:0] blink_q,  blink_d;
    logic [6:0]    char_d;

    logic [3:0]    an_q;
    logic [6:0]    char_q;
    logic          fs_q;

    sseg_prescaler #(
        .DIV    (REFRESH_DIV)
    ) u_prescaler (
        .clk    (clk),
        .rst    (rst),
        .tick_o (tick)
    );

    assign frame_wrap = tick && (slot_q == 2'd3);
    assign xfer       = mode_valid && !pend_q;

    always_comb begin
        slot_d   = slot_q;
        active_d = active_q;
        pmode_d  = pmode_q;
        pend_d   = pend_q;
        blink_d  = blink_q;

        if (tick) slot_d = slot_q + 2'd1;

        if (frame_wrap) begin
            if (blink_q != '0) blink_d = blink_q - BW'(1);
            if (pend_q) begin
                active_d = pmode_q;
                pend_d   = 1'b0;
                // A commit of the mode already shown leaves any blink running as-is.
                if (pmode_q != active_q) blink_d = BLINK_LOAD;
            end
        end

        // Ready is low whenever pending is set, so this never races a commit.
        if (xfer) begin
            pend_d  = 1'b1;
            pmode_d = mode_t'(mode_in);
        end

        char_d = blink_d[0] ? SEG_BLANK : slot_char(slot_d, active_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q   <= 2'd0;
            active_q <= NONE;
            pmode_q  <= NONE;
            pend_q   <= 1'b0;
            blink_q  <= '0;
            an_q     <= AN_OFF;
            char_q   <= SEG_BLANK;
            fs_q     <= 1'b0;
        end else begin
            slot_q   <= slot_d;
            active_q <= active_d;
            pmode_q  <= pmode_d;
            pend_q   <= pend_d;
            blink_q  <= blink_d;
            an_q     <= slot_anode(slot_d);
            char_q   <= char_d;
            fs_q     <= frame_wrap;
        end
    end

    assign mode_ready  = !pend_q;
    assign an_sel      = an_q;
    assign char_sel    = char_q;
    assign frame_start = fs_q;

endmodule : sseg_scan_ctrl
`default_nettype wire

// File: tb/tb_sseg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_sseg_scan_ctrl
// Brief   : Self-checking bench with a frame-level behavioural model.
// Revision: 1.0
// ============================================================================
module tb_sseg_scan_ctrl;

    localparam int RD = 4;
    localparam int BF = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] mode_in = 2'b00;
    logic       mode_valid = 1'b0;
    logic       mode_ready;
    logic [3:0] an_sel;
    logic [6:0] char_sel;
    logic       frame_start;

    int total = 0;
    int bad   = 0;

    sseg_scan_ctrl #(
        .REFRESH_DIV  (RD),
        .BLINK_FRAMES (BF)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mode_in     (mode_in),
        .mode_valid  (mode_valid),
        .mode_ready  (mode_ready),
        .an_sel      (an_sel),
        .char_sel    (char_sel),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    int         m_cyc, m_slot, m_frame, m_chg;
    int         m_active, m_pmode;
    bit         m_pend, m_rstd, m_fs;
    logic [3:0] an_tab [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    function automatic logic [6:0] model_char();
        logic [6:0] c;
        int k;
        c = 7'b1111111;
        if (m_slot == 0 && m_active == 3) c = 7'b0101111;
        if (m_slot == 1 && m_active == 2) c = 7'b0101011;
        if (m_slot == 2 && m_active == 1) c = 7'b0100001;
        // Frames after a changing commit count down from BF; odd remaining count is dark.
        k = m_frame - m_chg;
        if (k >= 1 && k <= BF && ((BF - k) % 2) == 1) c = 7'b1111111;
        return c;
    endfunction

    function automatic bit next_is_wrap();
        return (m_cyc % RD == RD - 1) && (m_slot == 3);
    endfunction

    task automatic model_step(input bit r, input bit v, input int m);
        bit tick, wrap, xfer;
        if (r) begin
            m_cyc = 0; m_slot = 0; m_frame = 0; m_chg = -1000;
            m_active = 0; m_pmode = 0; m_pend = 0; m_rstd = 1; m_fs = 0;
            return;
        end
        tick = (m_cyc % RD) == RD - 1;
        wrap = tick && (m_slot == 3);
        xfer = v && !m_pend;
        m_fs = wrap;
        if (tick) m_slot = (m_slot + 1) % 4;
        if (wrap) begin
            m_frame++;
            if (m_pend) begin
                if (m_pmode != m_active) m_chg = m_frame;
                m_active = m_pmode;
                m_pend   = 0;
            end
        end
        if (xfer) begin
            m_pend  = 1;
            m_pmode = m;
        end
        m_cyc++;
        m_rstd = 0;
    endtask

    task automatic compare_model();
        logic [3:0] e_an;
        logic [6:0] e_ch;
        logic       e_rdy, e_fs;
        if (m_rstd) begin
            e_an = 4'b1111; e_ch = 7'b1111111; e_rdy = 1'b1; e_fs = 1'b0;
        end else begin
            e_an = an_tab[m_slot]; e_ch = model_char(); e_rdy = !m_pend; e_fs = m_fs;
        end
        total++;
        if ({an_sel, char_sel, mode_ready, frame_start} !== {e_an, e_ch, e_rdy, e_fs}) begin
            bad++;
            $display("FAIL model t=%0t: got an=%b ch=%b rdy=%b fs=%b, want an=%b ch=%b rdy=%b fs=%b",
                     $time, an_sel, char_sel, mode_ready, frame_start, e_an, e_ch, e_rdy, e_fs);
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic step(input bit r, input bit v, input int m);
        rst        = r;
        mode_valid = v;
        mode_in    = 2'(m);
        model_step(r, v, m);
        @(negedge clk);
        compare_model();
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic wait_fs();
        int n;
        n = 0;
        do begin step(0, 0, 0); n++; end while (!frame_start && n < 64);
        if (!frame_start) chk("wait_frame_start_timeout", 0, 1);
    endtask

    task automatic wait_an(input logic [3:0] a);
        int n;
        n = 0;
        do begin step(0, 0, 0); n++; end while (an_sel !== a && n < 64);
        if (an_sel !== a) chk("wait_anode_timeout", 32'(an_sel), 32'(a));
    endtask

    initial begin
        int n;
        @(negedge clk);
        // 1: reset and idle scan
        step(1, 0, 0);
        step(1, 0, 0);
        chk("reset_an", 32'(an_sel), 32'h0F);
        chk("reset_char", 32'(char_sel), 32'h7F);
        chk("reset_ready", 32'(mode_ready), 1);
        chk("reset_fs", 32'(frame_start), 0);
        step(0, 0, 0);
        chk("first_slot_an", 32'(an_sel), 32'b1110);
        wait_fs();
        n = 0;
        do begin step(0, 0, 0); n++; end while (!frame_start && n < 64);
        chk("frame_period", n, 16);
        chk("idle_char", 32'(char_sel), 32'h7F);

        // 2: DRIVE request mid-frame, blink pattern
        step(0, 0, 0); step(0, 0, 0); step(0, 0, 0);
        step(0, 1, 1);
        chk("drive_ready_low", 32'(mode_ready), 0);
        wait_fs();
        chk("drive_ready_back", 32'(mode_ready), 1);
        wait_an(4'b1011); chk("drive_commit_frame", 32'(char_sel), 32'b0100001);
        wait_fs(); wait_an(4'b1011); chk("drive_blink_dark", 32'(char_sel), 32'h7F);
        wait_fs(); wait_an(4'b1011); chk("drive_blink_on", 32'(char_sel), 32'b0100001);
        wait_fs(); wait_an(4'b1011); chk("drive_steady", 32'(char_sel), 32'b0100001);

        // 4: same mode again, no blink
        step(0, 1, 1);
        chk("same_ready_low", 32'(mode_ready), 0);
        wait_fs(); wait_an(4'b1011); chk("same_f0", 32'(char_sel), 32'b0100001);
        wait_fs(); wait_an(4'b1011); chk("same_f1", 32'(char_sel), 32'b0100001);

        // 3: REVERSE held valid while not ready
        step(0, 1, 3);
        n = 0;
        while (!mode_ready && n < 64) begin step(0, 1, 3); n++; end
        step(0, 0, 0);
        wait_fs(); wait_fs(); wait_fs();
        wait_an(4'b1110); chk("rev_slot0", 32'(char_sel), 32'b0101111);
        wait_an(4'b1011); chk("rev_slot2_blank", 32'(char_sel), 32'h7F);

        // 5: reset during a blink frame with a request pending
        step(0, 1, 2);
        wait_fs();
        wait_fs();
        step(0, 1, 1);
        step(0, 0, 0);
        step(1, 0, 0);
        chk("midblink_rst_an", 32'(an_sel), 32'h0F);
        chk("midblink_rst_char", 32'(char_sel), 32'h7F);
        chk("midblink_rst_ready", 32'(mode_ready), 1);
        wait_fs(); wait_fs();
        wait_an(4'b1011); chk("pending_dropped", 32'(char_sel), 32'h7F);

        // 6: valid on the wrap tick commits one frame later
        n = 0;
        while (!next_is_wrap() && n < 64) begin step(0, 0, 0); n++; end
        step(0, 1, 2);
        chk("wrap_xfer_ready_low", 32'(mode_ready), 0);
        n = 0;
        while (!mode_ready && n < 64) begin step(0, 0, 0); n++; end
        chk("wrap_commit_latency", n, 16);

        // Randomised traffic
        for (int i = 0; i < 4000; i++) begin
            step(($urandom_range(0, 399) == 0), ($urandom_range(0, 7) == 0), int'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_sseg_scan_ctrl
`default_nettype wire
